// File: rtl/vdp_pkg.sv
// Shared VDP definitions: VRAM geometry, arbiter defaults and CPU read FSM encoding.
package vdp_pkg;

  localparam int unsigned VramBits = 16;
  localparam logic [7:0] DefaultStarveLimit = 8'd200;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StCapture = 2'd2,
    StAck     = 2'd3
  } rd_state_e;

endpackage

// File: rtl/vram_write_buffer.sv
// One-entry posted-write buffer for CPU writes into VRAM.
module vram_write_buffer
  import vdp_pkg::*;
#(
  parameter int unsigned RamBits = VramBits
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               drain,
  input  logic [RamBits-1:0] loadAddr,
  input  logic [7:0]         loadData,
  output logic               wbValid,
  output logic [RamBits-1:0] wbAddr,
  output logic [7:0]         wbData
);

  // Load captures a write when empty; drain frees the entry once its RAM slot is used.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbValid <= 1'b0;
      wbAddr  <= '0;
      wbData  <= 8'h00;
    end else if (load) begin
      wbValid <= 1'b1;
      wbAddr  <= loadAddr;
      wbData  <= loadData;
    end else if (drain) begin
      wbValid <= 1'b0;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VDP display fetches always win, CPU accesses fill idle slots.
module vram_arbiter
  import vdp_pkg::*;
#(
  parameter int unsigned RamBits     = VramBits,
  parameter logic [7:0]  StarveLimit = DefaultStarveLimit
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vdpReq,
  input  logic [RamBits-1:0] vdpAddr,
  output logic [7:0]         vdpData,
  input  logic               cpuReq,
  input  logic               cpuWe,
  input  logic [RamBits-1:0] cpuAddr,
  input  logic [7:0]         cpuWData,
  output logic               cpuAck,
  output logic [7:0]         cpuRData,
  output logic               cpuStarved,
  output logic [RamBits-1:0] ramAddress,
  output logic               ramWriteEnabled,
  output logic [7:0]         ramDataIn,
  input  logic [7:0]         ramDataOut
);

  rd_state_e          state;
  logic [RamBits-1:0] rdAddr;
  logic [7:0]         waitCnt;
  logic [7:0]         waitCntNext;

  logic               wbValid;
  logic [RamBits-1:0] wbAddr;
  logic [7:0]         wbData;

  logic               cpuIdle;
  logic               wrAccept;
  logic               rdAccept;
  logic               wbDrain;
  logic               rdGrant;

  // The ack cycle is excluded so a request still held during its ack is not taken twice.
  assign cpuIdle  = (state == StIdle) && !wbValid && !cpuAck;
  assign wrAccept = cpuReq && cpuWe && cpuIdle;
  assign rdAccept = cpuReq && !cpuWe && cpuIdle;
  assign wbDrain  = wbValid && !vdpReq;
  assign rdGrant  = (state == StIssue) && !vdpReq && !wbValid;

  assign vdpData = ramDataOut;

  vram_write_buffer #(
    .RamBits (RamBits)
  ) u_write_buffer (
    .clk      (clk),
    .reset    (reset),
    .load     (wrAccept),
    .drain    (wbDrain),
    .loadAddr (cpuAddr),
    .loadData (cpuWData),
    .wbValid  (wbValid),
    .wbAddr   (wbAddr),
    .wbData   (wbData)
  );

  // RAM slot select: VDP, then buffered write, then CPU read, else idle.
  always_comb begin
    ramAddress      = '0;
    ramWriteEnabled = 1'b0;
    ramDataIn       = 8'h00;
    if (vdpReq) begin
      ramAddress = vdpAddr;
    end else if (wbValid) begin
      ramAddress      = wbAddr;
      ramWriteEnabled = 1'b1;
      ramDataIn       = wbData;
    end else if (state == StIssue) begin
      ramAddress = rdAddr;
    end
  end

  // CPU read FSM plus the registered ack pulse shared by reads and writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= StIdle;
      rdAddr   <= '0;
      cpuAck   <= 1'b0;
      cpuRData <= 8'h00;
    end else begin
      cpuAck <= 1'b0;
      unique case (state)
        StIdle: begin
          if (rdAccept) begin
            rdAddr <= cpuAddr;
            state  <= StIssue;
          end else if (wrAccept) begin
            cpuAck <= 1'b1;
          end
        end
        StIssue: begin
          if (rdGrant) state <= StCapture;
        end
        StCapture: begin
          // RAM is synchronous: data for the granted slot is on ramDataOut now.
          cpuRData <= ramDataOut;
          cpuAck   <= 1'b1;
          state    <= StAck;
        end
        StAck: begin
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Saturating wait counter; cleared on ack or when no request is pending.
  always_comb begin
    waitCntNext = 8'h00;
    if (cpuReq && !cpuAck) begin
      waitCntNext = (waitCnt == 8'hFF) ? 8'hFF : waitCnt + 8'h01;
    end
  end

  // Starvation flag tracks the counter's next value so it drops the cycle after ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitCnt    <= 8'h00;
      cpuStarved <= 1'b0;
    end else begin
      waitCnt    <= waitCntNext;
      cpuStarved <= (waitCntNext >= StarveLimit);
    end
  end

endmodule
